alu_exec_unit: RTL and testbench

- MIPS single-cycle execute stage combining three functions: ALU control decode, 32-bit ALU, and branch AND gate.
- Decodes the 2-bit main-control ALUOp plus the instruction funct field into a 4-bit ALU operation.
- Executes that operation on two 32-bit operands and produces the zero flag.
- ANDs the zero flag with the control Branch bit to give the PC-select signal.

---
 rtl/alu_exec_unit.sv | 140 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS single-cycle execute stage.
//   Decodes ALUOp/funct into a 4-bit ALU operation, executes it on two
//   operands, and gates the zero flag with Branch to select the next PC.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   alu_op[1:0]     ALUOp from main control
//   funct[5:0]      instruction[5:0]
//   a, b [WIDTH]    operands (b already muxed between register/immediate)
//   branch          Branch bit from main control
//   alu_ctrl[3:0]   decoded ALU operation (combinational)
//   result [WIDTH]  ALU result (registered)
//   zero            result == 0 (registered; forced low during reset)
//   take_branch     branch & zero (registered)
//   illegal         unsupported operation (registered)
//   overflow        signed overflow for add/sub (registered when
//                   ALU_OVERFLOW_EN is defined, otherwise constant 0)
//
// Build option: define ALU_OVERFLOW_EN to enable the overflow flag.

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             branch,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             take_branch,
  output logic             illegal,
  output logic             overflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_ILL = 4'b1111;

  // ALU control decode
  always_comb begin
    alu_ctrl = OP_ADD;
    unique case (alu_op)
      2'b00:   alu_ctrl = OP_ADD;
      2'b01:   alu_ctrl = OP_SUB;
      2'b11:   alu_ctrl = OP_ADD;
      default: begin
        unique case (funct)
          6'b100000: alu_ctrl = OP_ADD;
          6'b100010: alu_ctrl = OP_SUB;
          6'b100100: alu_ctrl = OP_AND;
          6'b100101: alu_ctrl = OP_OR;
          6'b101010: alu_ctrl = OP_SLT;
          6'b100111: alu_ctrl = OP_NOR;
          default:   alu_ctrl = OP_ILL;
        endcase
      end
    endcase
  end

  // Datapath
  logic [WIDTH-1:0] sum, diff;
  logic             slt;

  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = $signed(a) < $signed(b);

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             take_d, take_q;
  logic             ill_d, ill_q;

  always_comb begin
    result_d = '0;
    ill_d    = 1'b0;
    case (alu_ctrl)
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_ADD:  result_d = sum;
      OP_SUB:  result_d = diff;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  result_d = ~(a | b);
      default: ill_d    = 1'b1;
    endcase
    // Illegal ops yield result 0, so zero is asserted for them too.
    zero_d = (result_d == '0);
    take_d = branch & zero_d;
  end

  // Reset forces zero low even though result is 0 at that point.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      take_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      take_q   <= take_d;
      ill_q    <= ill_d;
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign take_branch = take_q;
  assign illegal     = ill_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    case (alu_ctrl)
      OP_ADD:  ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
      OP_SUB:  ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a, b;
  logic        branch;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero, take_branch, illegal, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        tb;
    logic        ill;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .branch(branch), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
    .take_branch(take_branch), .illegal(illegal), .overflow(overflow)
  );

  // Overflow is only expected when the feature is built in.
`ifdef ALU_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One directed step: drive on negedge, check decode, push the expected
  // registered outputs, then pop and compare after the next rising edge.
  task automatic step(input string tag, input logic r, input logic [1:0] op,
                      input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                      input logic br, input logic [3:0] e_ctrl,
                      input logic [31:0] e_res, input logic e_z, input logic e_tb,
                      input logic e_ill, input logic e_ovf);
    exp_t e, o;
    @(negedge clk);
    rst = r; alu_op = op; funct = f; a = av; b = bv; branch = br;
    #1;
    chk({tag, ".ctrl"}, {28'd0, alu_ctrl}, {28'd0, e_ctrl});
    e.res = e_res; e.z = e_z; e.tb = e_tb; e.ill = e_ill; e.ovf = e_ovf & OVF_EN;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() == 1) else begin
      errors++;
      $error("FAIL %s.sb: got %0d entries expected 1", tag, sb.size());
    end
    o = sb.pop_front();
    chk({tag, ".result"}, result,               o.res);
    chk({tag, ".zero"},   {31'd0, zero},        {31'd0, o.z});
    chk({tag, ".take"},   {31'd0, take_branch}, {31'd0, o.tb});
    chk({tag, ".ill"},    {31'd0, illegal},     {31'd0, o.ill});
    chk({tag, ".ovf"},    {31'd0, overflow},    {31'd0, o.ovf});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; alu_op = 2'b00; funct = 6'd0; a = '0; b = '0; branch = 1'b0;
    //    tag         rst op     funct      a             b             br ctrl     result        z  tb ill ovf
    step("rst0",      1, 2'b01, 6'b000000, 32'd5,        32'd5,        1, 4'b0110, 32'h0,        0, 0, 0, 0);
    step("rst1",      1, 2'b01, 6'b000000, 32'd5,        32'd5,        1, 4'b0110, 32'h0,        0, 0, 0, 0);
    step("beq_eq",    0, 2'b01, 6'b000000, 32'd5,        32'd5,        1, 4'b0110, 32'h0,        1, 1, 0, 0);
    step("add",       0, 2'b10, 6'b100000, 32'h7,        32'h3,        0, 4'b0010, 32'hA,        0, 0, 0, 0);
    step("slt_lt",    0, 2'b10, 6'b101010, 32'hFFFFFFFE, 32'h1,        0, 4'b0111, 32'h1,        0, 0, 0, 0);
    step("slt_ge",    0, 2'b10, 6'b101010, 32'h1,        32'hFFFFFFFE, 1, 4'b0111, 32'h0,        1, 1, 0, 0);
    step("slt_min",   0, 2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 0, 4'b0111, 32'h1,        0, 0, 0, 0);
    step("nor",       0, 2'b10, 6'b100111, 32'h0F0F0000, 32'h00F0F000, 0, 4'b1100, 32'hF0000FFF, 0, 0, 0, 0);
    step("and",       0, 2'b10, 6'b100100, 32'hFFFF0000, 32'h0000FFFF, 0, 4'b0000, 32'h0,        1, 0, 0, 0);
    step("or",        0, 2'b10, 6'b100101, 32'h10,       32'h4,        0, 4'b0001, 32'h14,       0, 0, 0, 0);
    step("sub_nz",    0, 2'b10, 6'b100010, 32'd9,        32'd4,        1, 4'b0110, 32'h5,        0, 0, 0, 0);
    step("illegal",   0, 2'b10, 6'b000011, 32'h1234,     32'h5678,     1, 4'b1111, 32'h0,        1, 1, 1, 0);
    step("lw_add",    0, 2'b00, 6'b000011, 32'h10,       32'h4,        0, 4'b0010, 32'h14,       0, 0, 0, 0);
    step("add_wrap",  0, 2'b00, 6'b000000, 32'hFFFFFFFF, 32'h1,        0, 4'b0010, 32'h0,        1, 0, 0, 0);
    step("add_ovf",   0, 2'b00, 6'b000000, 32'h7FFFFFFF, 32'h1,        0, 4'b0010, 32'h80000000, 0, 0, 0, 1);
    step("sub_ovf",   0, 2'b01, 6'b000000, 32'h80000000, 32'h1,        0, 4'b0110, 32'h7FFFFFFF, 0, 0, 0, 1);
    step("op11_add",  0, 2'b11, 6'b100010, 32'd2,        32'd3,        0, 4'b0010, 32'h5,        0, 0, 0, 0);
    step("rst_mid",   1, 2'b00, 6'b000000, 32'h7FFFFFFF, 32'h1,        1, 4'b0010, 32'h0,        0, 0, 0, 0);
    step("post_rst",  0, 2'b10, 6'b100100, 32'hF0,       32'h0F,       1, 4'b0000, 32'h0,        1, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
